// File: rtl/lifo_stack_pkg.sv
// lifo_stack_pkg: shared definitions for the parametrised LIFO stack.
//   op_e        - per-cycle operation decode of {push, pop}
//   DEF_WIDTH   - default word width (call/return address width)
//   DEF_DEPTH   - default number of entries
package lifo_stack_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_DEPTH = 256;

endpackage

// File: rtl/lifo_stack_if.sv
// lifo_stack_if: request/status bundle for lifo_stack.
//   master: drives clear, push, pop, in_data; observes status.
//   slave : the stack itself; drives out_data, count, full, empty,
//           overflow, underflow (and hwm when LIFO_STACK_HWM_EN is defined).
interface lifo_stack_if
    import lifo_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clear;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;
`ifdef LIFO_STACK_HWM_EN
    logic [CNT_W-1:0] hwm;

    modport master (
        output clear, push, pop, in_data,
        input  out_data, count, full, empty, overflow, underflow, hwm
    );
    modport slave (
        input  clear, push, pop, in_data,
        output out_data, count, full, empty, overflow, underflow, hwm
    );
`else
    modport master (
        output clear, push, pop, in_data,
        input  out_data, count, full, empty, overflow, underflow
    );
    modport slave (
        input  clear, push, pop, in_data,
        output out_data, count, full, empty, overflow, underflow
    );
`endif

endinterface

// File: rtl/lifo_stack_mem.sv
// lifo_stack_mem: DEPTH x WIDTH storage array for lifo_stack.
//   clk          - rising-edge clock for the write port
//   we/waddr/wdata - synchronous write port
//   raddr/rdata  - asynchronous read port
// Contents are never reset.
module lifo_stack_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO with replace-top, occupancy and sticky
// overflow/underflow flags.
//   clk   - rising-edge clock
//   reset - synchronous active-high reset (highest priority)
//   bus   - lifo_stack_if slave: clear/push/pop/in_data in;
//           out_data (combinational top, 0 when empty), count, full, empty,
//           overflow, underflow out.
// Optional: define LIFO_STACK_HWM_EN to add bus.hwm, the maximum count
// reached since the last reset or clear.
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        reset,
    lifo_stack_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    op_e              op;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             full, empty;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;

    assign op    = op_e'({bus.push, bus.pop});
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // Wraps when empty; out_data is forced to 0 in that case.
    assign raddr = AW'(count_q - CNT_W'(1));

    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        we          = 1'b0;
        waddr       = '0;
        case (op)
            OP_NOP: ;
            OP_PUSH: begin
                if (full) begin
                    overflow_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    waddr   = AW'(count_q);
                    count_d = count_q + CNT_W'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    underflow_d = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            OP_REPLACE: begin
                we = 1'b1;
                if (empty) begin
                    waddr       = '0;
                    count_d     = CNT_W'(1);
                    underflow_d = 1'b1;
                end else begin
                    waddr = raddr;
                end
            end
        endcase
        if (bus.clear) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            we          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    lifo_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we && !reset),
        .waddr (waddr),
        .wdata (bus.in_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign bus.out_data  = empty ? '0 : rdata;
    assign bus.count     = count_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

`ifdef LIFO_STACK_HWM_EN
    logic [CNT_W-1:0] hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (bus.clear) begin
            hwm_d = '0;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign bus.hwm = hwm_q;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed and random checks of lifo_stack against a
// queue-based reference model. Instance 0 uses DEPTH=256, instance 1
// uses DEPTH=4 to reach the full boundary.
module tb_lifo_stack;

    logic clk;
    logic rst;

    lifo_stack_if #(.WIDTH(10), .DEPTH(256)) bus0 ();
    lifo_stack_if #(.WIDTH(10), .DEPTH(4))   bus1 ();

    lifo_stack #(.WIDTH(10), .DEPTH(256)) dut0 (.clk(clk), .reset(rst), .bus(bus0));
    lifo_stack #(.WIDTH(10), .DEPTH(4))   dut1 (.clk(clk), .reset(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    bit         ovf_m[2];
    bit         unf_m[2];
    int         hwm_m[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int w, input bit pu, input bit po, input bit cl,
                              input logic [9:0] d);
        logic [9:0] q[$];
        int dep;
        if (w == 0) begin q = q0; dep = 256; end
        else        begin q = q1; dep = 4;   end
        if (cl) begin
            q.delete();
            ovf_m[w] = 1'b0;
            unf_m[w] = 1'b0;
            hwm_m[w] = 0;
        end else begin
            if (pu && !po) begin
                if (q.size() == dep) ovf_m[w] = 1'b1;
                else q.push_back(d);
            end else if (!pu && po) begin
                if (q.size() == 0) unf_m[w] = 1'b1;
                else void'(q.pop_back());
            end else if (pu && po) begin
                if (q.size() == 0) begin
                    unf_m[w] = 1'b1;
                    q.push_back(d);
                end else begin
                    q[q.size()-1] = d;
                end
            end
            if (q.size() > hwm_m[w]) hwm_m[w] = q.size();
        end
        if (w == 0) q0 = q;
        else        q1 = q;
    endtask

    task automatic compare_model(input int w);
        logic [9:0] top;
        int sz, dep;
        if (w == 0) begin
            sz = q0.size(); dep = 256; top = (sz != 0) ? q0[sz-1] : 10'h000;
            chk("m0_out",   32'(bus0.out_data),  32'(top));
            chk("m0_count", 32'(bus0.count),     32'(sz));
            chk("m0_full",  32'(bus0.full),      32'(sz == dep));
            chk("m0_empty", 32'(bus0.empty),     32'(sz == 0));
            chk("m0_ovf",   32'(bus0.overflow),  32'(ovf_m[0]));
            chk("m0_unf",   32'(bus0.underflow), 32'(unf_m[0]));
`ifdef LIFO_STACK_HWM_EN
            chk("m0_hwm",   32'(bus0.hwm),       32'(hwm_m[0]));
`endif
        end else begin
            sz = q1.size(); dep = 4; top = (sz != 0) ? q1[sz-1] : 10'h000;
            chk("m1_out",   32'(bus1.out_data),  32'(top));
            chk("m1_count", 32'(bus1.count),     32'(sz));
            chk("m1_full",  32'(bus1.full),      32'(sz == dep));
            chk("m1_empty", 32'(bus1.empty),     32'(sz == 0));
            chk("m1_ovf",   32'(bus1.overflow),  32'(ovf_m[1]));
            chk("m1_unf",   32'(bus1.underflow), 32'(unf_m[1]));
`ifdef LIFO_STACK_HWM_EN
            chk("m1_hwm",   32'(bus1.hwm),       32'(hwm_m[1]));
`endif
        end
    endtask

    task automatic idle_all();
        bus0.push = 1'b0; bus0.pop = 1'b0; bus0.clear = 1'b0; bus0.in_data = '0;
        bus1.push = 1'b0; bus1.pop = 1'b0; bus1.clear = 1'b0; bus1.in_data = '0;
    endtask

    // One clock with the given request on instance w, the other idle.
    task automatic step(input int w, input bit pu, input bit po, input bit cl,
                        input logic [9:0] d);
        idle_all();
        if (w == 0) begin
            bus0.push = pu; bus0.pop = po; bus0.clear = cl; bus0.in_data = d;
        end else begin
            bus1.push = pu; bus1.pop = po; bus1.clear = cl; bus1.in_data = d;
        end
        @(posedge clk);
        #1;
        model_step(w, pu, po, cl, d);
        idle_all();
        compare_model(w);
    endtask

    // Reset asserted together with a push: reset must win.
    task automatic do_reset();
        idle_all();
        bus0.push = 1'b1; bus0.in_data = 10'h3C3;
        bus1.push = 1'b1; bus1.in_data = 10'h3C3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_all();
        q0.delete(); q1.delete();
        ovf_m = '{1'b0, 1'b0};
        unf_m = '{1'b0, 1'b0};
        hwm_m = '{0, 0};
        compare_model(0);
        compare_model(1);
    endtask

    initial begin
        bit pu, po, cl;
        rst = 1'b0;
        idle_all();
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        chk("rst_count", 32'(bus0.count), 32'd0);
        chk("rst_empty", 32'(bus0.empty), 32'd1);
        chk("rst_full",  32'(bus0.full),  32'd0);
        chk("rst_out",   32'(bus0.out_data), 32'd0);

        // Push three, pop three
        step(0, 1, 0, 0, 10'h001);
        step(0, 1, 0, 0, 10'h002);
        step(0, 1, 0, 0, 10'h003);
        chk("t1_count", 32'(bus0.count), 32'd3);
        chk("t1_top",   32'(bus0.out_data), 32'h003);
        step(0, 0, 1, 0, '0);
        chk("t1_pop1", 32'(bus0.out_data), 32'h002);
        step(0, 0, 1, 0, '0);
        chk("t1_pop2", 32'(bus0.out_data), 32'h001);
        step(0, 0, 1, 0, '0);
        chk("t1_pop3", 32'(bus0.out_data), 32'h000);
        chk("t1_empty", 32'(bus0.empty), 32'd1);

        // DEPTH=4: fill, overflow, replace when full
        do_reset();
        step(1, 1, 0, 0, 10'h00A);
        step(1, 1, 0, 0, 10'h00B);
        step(1, 1, 0, 0, 10'h00C);
        step(1, 1, 0, 0, 10'h00D);
        step(1, 1, 0, 0, 10'h3FF);
        chk("t2_full",  32'(bus1.full), 32'd1);
        chk("t2_count", 32'(bus1.count), 32'd4);
        chk("t2_top",   32'(bus1.out_data), 32'h00D);
        chk("t2_ovf",   32'(bus1.overflow), 32'd1);
        step(1, 1, 1, 0, 10'h155);
        chk("t2_rep_top",   32'(bus1.out_data), 32'h155);
        chk("t2_rep_count", 32'(bus1.count), 32'd4);
        step(1, 0, 1, 0, '0);
        chk("t2_below", 32'(bus1.out_data), 32'h00C);

        // Underflow on empty pop, then push
        do_reset();
        step(0, 0, 1, 0, '0);
        chk("t3_count", 32'(bus0.count), 32'd0);
        chk("t3_unf",   32'(bus0.underflow), 32'd1);
        chk("t3_out",   32'(bus0.out_data), 32'd0);
        step(0, 1, 0, 0, 10'h020);
        chk("t3_count2", 32'(bus0.count), 32'd1);
        chk("t3_unf2",   32'(bus0.underflow), 32'd1);

        // Replace on empty
        do_reset();
        step(0, 1, 1, 0, 10'h2AA);
        chk("t4_count", 32'(bus0.count), 32'd1);
        chk("t4_out",   32'(bus0.out_data), 32'h2AA);
        chk("t4_unf",   32'(bus0.underflow), 32'd1);

        // Clear beats push; next push lands at the bottom
        do_reset();
        step(0, 1, 0, 0, 10'h011);
        step(0, 1, 0, 0, 10'h022);
        step(0, 0, 1, 0, '0);
        step(0, 0, 1, 0, '0);
        step(0, 0, 1, 0, '0);
        step(0, 1, 0, 0, 10'h011);
        step(0, 1, 0, 0, 10'h022);
        step(0, 1, 0, 1, 10'h033);
        chk("t5_count", 32'(bus0.count), 32'd0);
        chk("t5_empty", 32'(bus0.empty), 32'd1);
        chk("t5_unf",   32'(bus0.underflow), 32'd0);
        chk("t5_out",   32'(bus0.out_data), 32'd0);
        step(0, 1, 0, 0, 10'h044);
        chk("t5_top",   32'(bus0.out_data), 32'h044);
        chk("t5_count2", 32'(bus0.count), 32'd1);

`ifdef LIFO_STACK_HWM_EN
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 10'(i + 1));
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, '0);
        step(0, 1, 0, 0, 10'h077);
        chk("hwm_peak",  32'(bus0.hwm), 32'd5);
        chk("hwm_count", 32'(bus0.count), 32'd3);
        do_reset();
        chk("hwm_rst",   32'(bus0.hwm), 32'd0);
`endif

        // Random traffic on the shallow instance
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cl = ($urandom_range(0, 31) == 0);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            step(1, pu, po, cl, 10'($urandom_range(0, 1023)));
        end

        // Random traffic on the deep instance
        for (int i = 0; i < 300; i++) begin
            cl = ($urandom_range(0, 63) == 0);
            pu = ($urandom_range(0, 99) < 60);
            po = ($urandom_range(0, 99) < 40);
            step(0, pu, po, cl, 10'($urandom_range(0, 1023)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Parametrised LIFO buffer; successor of the fixed 10-bit × 256 stack used for call/return addresses in the pipelined CPU.
- Adds configurable width and depth, plus synchronous reset and clear.
- A simultaneous push+pop performs a replace-top.
- Exposes occupancy and full/empty status, with sticky overflow/underflow error flags for the control unit's trap logic.

Parameters:
- WIDTH, 10, data word width in bits.
- DEPTH, 256, number of entries; any value ≥ 2, not required to be a power of two.
- CNT_W, $clog2(DEPTH+1), width of the occupancy counter (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush: empties the stack and clears the error flags.
- push  input  1  push request.
- pop  input  1  pop request.
- in_data  input  WIDTH  word to push.
- out_data  output  WIDTH  current top of stack (combinational); 0 when empty.
- count  output  CNT_W  number of valid entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a push was dropped because the stack was full.
- underflow  output  1  sticky: a pop was issued while the stack was empty.

Behaviour:
- Reset (reset=1 at a posedge): count=0, overflow=0, underflow=0. Storage contents are not cleared. out_data=0, empty=1, full=0. reset has priority over every other input.
- clear: identical effect to reset on count and the flags. It has priority over push and pop in the same cycle.
- out_data = empty ? 0 : mem[count-1]. It is purely combinational, so there is zero read latency. A pushed word appears on out_data in the cycle after the push edge.
- Operation decode per cycle, with op = {push, pop}:
  - NOP (00): no change.
  - PUSH (10), not full: mem[count] <= in_data; count+1.
  - PUSH (10), full: write dropped; count unchanged; overflow <= 1.
  - POP (01), not empty: count-1. Memory is not modified.
  - POP (01), empty: count stays 0; underflow <= 1.
  - REPLACE (11), not empty: mem[count-1] <= in_data; count unchanged. Valid when full; never sets overflow.
  - REPLACE (11), empty: mem[0] <= in_data; count=1; underflow <= 1.
- Only non-blocking assignments. count never exceeds DEPTH and never wraps below 0.
- full and empty are decoded from count, never held as separate state.
- Flags stay set until reset or clear.
- Reset or clear mid-sequence discards all entries. The next push lands at mem[0].

Optional Feature:
- Macro: LIFO_STACK_HWM_EN.
- Defined:
  - Adds output hwm [CNT_W-1:0], the high-water mark: maximum count reached since the last reset or clear.
  - Updated at the same posedge as count: hwm <= max(hwm, next_count).
  - Reset and clear set it to 0.
- Undefined: the port and its register are absent; no other behaviour changes.

Decomposition:
- Package lifo_stack_pkg:
  - Op encoding constants: OP_NOP=2'b00, OP_POP=2'b01, OP_PUSH=2'b10, OP_REPLACE=2'b11.
  - Default WIDTH/DEPTH constants shared with the CPU's call/return path.
- Sub-module lifo_stack_mem:
  - DEPTH × WIDTH array; one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
  - The top level holds count, the flags, decode and the optional HWM.

Test Plan:
- reset, then push 0x001, 0x002, 0x003 on consecutive cycles -> count=3, out_data=0x003; three pops -> out_data 0x002, 0x001, 0, with empty=1 after the third.
- DEPTH=4: push 0x00A..0x00D, then push 0x3FF -> full=1, count=4, out_data=0x00D, overflow=1. A following REPLACE with 0x155 -> out_data=0x155, count=4.
- pop on empty after reset -> count=0, underflow=1, out_data=0. A subsequent push of 0x020 -> count=1, underflow still 1.
- REPLACE on empty with 0x2AA -> count=1, out_data=0x2AA, underflow=1.
- push 0x011, 0x022, then assert clear together with push of 0x033 -> count=0, empty=1, flags 0, out_data=0. The next push of 0x044 -> out_data=0x044, count=1.
- With LIFO_STACK_HWM_EN: 5 pushes, 3 pops, 1 push -> hwm=5, count=3; after reset -> hwm=0.
